dmem_wbuf: RTL
==============

# dmem_wbuf

Data-memory responder for the pipeline's load/store path: it serves the word reads the writeback stage uses for loads and store merging, and it accepts the full 32-bit merged words that stage writes back. Writes enter a small FIFO store buffer and drain into a single-port synchronous word array when the array port is idle. Reads forward from the buffer so that read-after-write is always coherent. The block sits directly below the writeback stage and replaces a bare RAM.

## Interface
Parameters:
- `WORDS`, 1024: array depth in 32-bit words; must be a power of two. `AW = log2(WORDS)`.
- `WB_DEPTH`, 4: store-buffer entries; must be a power of two, ≥2.

Ports:
- `clk` in 1: the single clock; everything is rising-edge.
- `arst_n` in 1: reset, asynchronous and active-low.
- `mem_r_ena_i` in 1: read request this cycle.
- `mem_r_addr_i` in 32: byte address of the read.
- `mem_r_data_o` out 32: read word, valid one cycle after the request.
- `mem_r_valid_o` out 1: qualifies `mem_r_data_o`.
- `mem_w_ena_i` in 1: write request, carrying a full merged word.
- `mem_w_addr_i` in 32: byte address of the write.
- `mem_w_data_i` in 32: write word.
- `mem_w_ready_o` out 1: buffer can accept a write; equals `!full`.
- `wbuf_empty_o` out 1: buffer empty and no drain in flight (used for fence/debug).

## Operation
- Word index is `addr[AW+1:2]`.
  - Bits [1:0] are ignored; sub-word merging is done upstream.
  - Bits above `AW+1` are ignored, so addresses alias and wrap modulo `WORDS`.
- Store buffer: circular FIFO with `head`, `tail` and a `count` of width `log2(WB_DEPTH)+1`.
  - Each entry holds `{index, data}`.
  - `full = (count == WB_DEPTH)`; `empty = (count == 0)`.
- Enqueue: when `mem_w_ena_i && mem_w_ready_o`, write the entry at `tail` and advance `tail` (wraps at `WB_DEPTH`).
  - A write presented while full is not accepted.
  - Upstream must hold it until `mem_w_ready_o`; the block never drops an accepted write.
  - Writes to an address already in the buffer are appended, not coalesced.
- Array port: one access per cycle.
  - Priority 1: read (`mem_r_ena_i`).
  - Priority 2: drain. When there is no read and the buffer is not empty, write entry `head` into the array and advance `head`.
- Read data is a registered result. Sources, in priority order:
  1. The incoming write in the same cycle, if `mem_w_ena_i && mem_w_ready_o` and the indices match.
  2. The youngest buffered entry with a matching index; youngest is nearest `tail`.
  3. The array word.
- The forwarding hit must be sampled in the request cycle. The selected value is what appears at the output on the next edge.
- Simultaneous enqueue and drain leaves `count` unchanged.
- Drain-starvation: with continuous reads the buffer never drains. This is accepted; the pipeline guarantees idle cycles.
- Array contents are not reset. Initialization is testbench-only (`$readmemh`).

## Timing
- Reset values (asynchronous, while `arst_n == 0`):
  - `mem_r_data_o = 0`, `mem_r_valid_o = 0`.
  - `head = tail = count = 0`, so `mem_w_ready_o = 1` and `wbuf_empty_o = 1`.
- Reset mid-operation discards all buffered, undrained writes. Array words already drained are retained.
- Read latency is exactly 1 cycle: a request at edge N gives data and `mem_r_valid_o = 1` after edge N+1.
  - `mem_r_valid_o` falls the cycle after `mem_r_ena_i` falls.
  - `mem_r_data_o` holds its last value when not valid.
- Write acceptance takes 0 cycles: the accept is combinational on `mem_w_ready_o`, and the entry is visible to forwarding from the same cycle.
- `mem_w_ready_o` deasserts the cycle after `count` reaches `WB_DEPTH`. It reasserts the cycle after the first drain from full.
  - A full buffer with a simultaneous drain and a write request does not accept the write that cycle, because ready is derived from registered `count`.
- A drain writes the array at the edge. A read of the same index in the following cycle returns the drained value from the array; no forwarding is needed.

## Test plan
- Reset and basic read/write:
  - Sequence: reset; write 0xDEADBEEF to 0x100; two idle cycles; read 0x100.
  - Required: `mem_r_data_o = 0xDEADBEEF` with valid one cycle later; `wbuf_empty_o = 1` before the read.
- Same-cycle forwarding:
  - Stimulus: read and write 0x0000_0204 (data 0x12345678) in the same cycle, with 0x204 previously holding 0xAAAAAAAA.
  - Required: read returns 0x12345678.
- Youngest-match forwarding:
  - Stimulus: under continuous reads to 0x0, write 0x40 := 1 then 0x40 := 2 (buffer holds both); then read 0x40.
  - Required: returns 2; after idle cycles the array holds 2.
- Full and backpressure:
  - Stimulus: hold `mem_r_ena_i = 1` on 0x0 and issue 5 writes with `WB_DEPTH = 4`.
  - Required: `mem_w_ready_o` is 0 after the 4th accept, and the 5th stays pending.
  - Then release reads: the 5th is accepted after the first drain, and all 5 land in order.
- Wrap-around and aliasing:
  - Stimulus: drive 10 write/drain cycles so the pointers wrap; then write 0x0000_1000 with `WORDS = 1024` and read 0x0.
  - Required: the read returns the 0x1000 data (alias).
- Reset mid-drain:
  - Stimulus: 3 buffered writes to 0x10, 0x14, 0x18 (the array previously 0); assert `arst_n = 0` after one drain.
  - Required: `mem_w_ready_o = 1` and `wbuf_empty_o = 1`; a later read returns the new data at 0x10 and 0 at 0x14 and 0x18.

Source files
------------

// File: rtl/dmem_wbuf.sv
// Data-memory responder: single-port word array behind a small FIFO store buffer.
// Reads are registered and forward from the buffer (youngest entry wins) for RAW coherence.
module dmem_wbuf #(
    parameter int WORDS    = 1024,
    parameter int WB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        mem_r_ena_i,
    input  logic [31:0] mem_r_addr_i,
    output logic [31:0] mem_r_data_o,
    output logic        mem_r_valid_o,
    input  logic        mem_w_ena_i,
    input  logic [31:0] mem_w_addr_i,
    input  logic [31:0] mem_w_data_i,
    output logic        mem_w_ready_o,
    output logic        wbuf_empty_o
);

    localparam int AW = $clog2(WORDS);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]    mem_q      [WORDS];
    logic [AW-1:0]  ent_idx_q  [WB_DEPTH];
    logic [31:0]    ent_data_q [WB_DEPTH];

    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           rvalid_q;

    logic [AW-1:0]  r_idx_s, w_idx_s;
    logic           full_s, empty_s, push_s, pop_s;
    logic           fwd_hit_s;
    logic [31:0]    fwd_data_s;
    logic           unused_addr_s;

    // Address bits outside the word index alias away.
    assign r_idx_s       = mem_r_addr_i[AW+1:2];
    assign w_idx_s       = mem_w_addr_i[AW+1:2];
    assign unused_addr_s = ^{mem_r_addr_i[31:AW+2], mem_r_addr_i[1:0],
                             mem_w_addr_i[31:AW+2], mem_w_addr_i[1:0]};

    assign full_s  = (count_q == CW'(WB_DEPTH));
    assign empty_s = (count_q == {CW{1'b0}});
    assign push_s  = mem_w_ena_i && !full_s;
    assign pop_s   = !mem_r_ena_i && !empty_s;

    assign mem_w_ready_o = !full_s;
    assign wbuf_empty_o  = empty_s;
    assign mem_r_data_o  = rdata_q;
    assign mem_r_valid_o = rvalid_q;

    // Forwarding search: walk oldest to youngest so the youngest match wins, then the incoming write.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = 32'h0000_0000;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if ((CW'(i) < count_q) && (ent_idx_q[head_q + PW'(i)] == r_idx_s)) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = ent_data_q[head_q + PW'(i)];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
        if (push_s && (w_idx_s == r_idx_s)) begin
            fwd_hit_s  = 1'b1;
            fwd_data_s = mem_w_data_i;
        end else begin
            fwd_hit_s  = fwd_hit_s;
            fwd_data_s = fwd_data_s;
        end
    end

    // Next-state for pointers, occupancy and read result.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        rdata_d = rdata_q;
        if (push_s) begin
            tail_d = tail_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            head_d = head_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            head_d = head_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        if (mem_r_ena_i) begin
            rdata_d = fwd_hit_s ? fwd_data_s : mem_q[r_idx_s];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Control and read-output registers; reset discards buffered writes.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            head_q   <= {PW{1'b0}};
            tail_q   <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            rdata_q  <= 32'h0000_0000;
            rvalid_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= mem_r_ena_i;
        end
    end

    // Buffer payload; slots are only meaningful while covered by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            ent_idx_q[tail_q]  <= w_idx_s;
            ent_data_q[tail_q] <= mem_w_data_i;
        end
    end

    // Word array write port: drains the head entry on cycles without a read.
    always_ff @(posedge clk) begin
        if (pop_s) begin
            mem_q[ent_idx_q[head_q]] <= ent_data_q[head_q];
        end
    end

endmodule
